w0rm_bus_arbiter: RTL

Two-master arbiter and sequencer sharing the W0RM core's single external bus between instruction fetch (read-only) and the bus/load-store unit. Sits between those units and the top-level `Address_o`/`Data_o`/`Read_o`/`Write_o`/`Valid_o`/`Data_i`/`Valid_i` pins. It serialises transactions, one outstanding at a time, with round-robin fairness and a registered response path.

---
 rtl/w0rm_bus_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/w0rm_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : w0rm_bus_arbiter
//  Purpose  : Two-master (fetch / load-store) arbiter and sequencer for the
//             single external bus. One transaction outstanding at a time,
//             round-robin on ties, registered response path.
//  Options  : W0RM_BUS_TIMEOUT_EN - enables the WAIT-state timeout counter
//             and the *_Err_o strobes (tied low otherwise).
//  Revision : 1.0 - initial release
// ============================================================================
module w0rm_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  BaseCLK,
  input  logic                  Reset,
  // instruction fetch side (read-only)
  input  logic                  IF_Req_i,
  input  logic [ADDR_WIDTH-1:0] IF_Addr_i,
  output logic [DATA_WIDTH-1:0] IF_Data_o,
  output logic                  IF_Valid_o,
  output logic                  IF_Err_o,
  // load/store side
  input  logic                  Mem_Req_i,
  input  logic [ADDR_WIDTH-1:0] Mem_Addr_i,
  input  logic [DATA_WIDTH-1:0] Mem_Data_i,
  input  logic                  Mem_Read_i,
  input  logic                  Mem_Write_i,
  output logic [DATA_WIDTH-1:0] Mem_Data_o,
  output logic                  Mem_Valid_o,
  output logic                  Mem_Err_o,
  // external bus
  output logic [ADDR_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] Data_o,
  output logic                  Read_o,
  output logic                  Write_o,
  output logic                  Valid_o,
  input  logic [DATA_WIDTH-1:0] Data_i,
  input  logic                  Valid_i,
  output logic                  Busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  state_t                state;
  logic                  last_grant;
  logic                  grant;
  logic                  pick_mem;
  logic                  mem_rd;
  logic                  mem_wr;
  logic                  finish;
  logic                  finish_err;
  logic [DATA_WIDTH-1:0] finish_word;

  // Tie-break: the data side wins unless it was the one granted last.
  assign pick_mem = Mem_Req_i & (~IF_Req_i | (last_grant == GRANT_IF));

  // Data-side direction: write dominates, "neither" degrades to a read.
  always_comb begin
    mem_rd = 1'b1;
    mem_wr = 1'b0;
    case ({Mem_Read_i, Mem_Write_i})
      2'b01, 2'b11: begin mem_rd = 1'b0; mem_wr = 1'b1; end
      default:      begin mem_rd = 1'b1; mem_wr = 1'b0; end
    endcase
  end

`ifdef W0RM_BUS_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Decide whether the transaction completes this cycle and with what data.
  always_comb begin
    finish      = 1'b0;
    finish_err  = 1'b0;
    finish_word = Data_i;
    if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
      finish = Valid_i;
`ifdef W0RM_BUS_TIMEOUT_EN
      // A response arriving in the timeout cycle takes precedence.
      if (!Valid_i && timeout_hit) begin
        finish      = 1'b1;
        finish_err  = 1'b1;
        finish_word = '0;
      end
`endif
    end
  end

  // Main sequencer: arbitration, command registers and response strobes.
  always_ff @(posedge BaseCLK) begin
    if (Reset) begin
      state       <= ST_IDLE;
      last_grant  <= GRANT_IF;
      grant       <= GRANT_IF;
      Address_o   <= '0;
      Data_o      <= '0;
      Read_o      <= 1'b0;
      Write_o     <= 1'b0;
      Valid_o     <= 1'b0;
      Busy_o      <= 1'b0;
      IF_Data_o   <= '0;
      IF_Valid_o  <= 1'b0;
      Mem_Data_o  <= '0;
      Mem_Valid_o <= 1'b0;
    end else begin
      Valid_o     <= 1'b0;
      IF_Valid_o  <= 1'b0;
      Mem_Valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (IF_Req_i || Mem_Req_i) begin
            grant   <= pick_mem;
            state   <= ST_ISSUE;
            Valid_o <= 1'b1;
            Busy_o  <= 1'b1;
            if (pick_mem) begin
              Address_o <= Mem_Addr_i;
              Data_o    <= Mem_Data_i;
              Read_o    <= mem_rd;
              Write_o   <= mem_wr;
            end else begin
              Address_o <= IF_Addr_i;
              Data_o    <= '0;
              Read_o    <= 1'b1;
              Write_o   <= 1'b0;
            end
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (finish) begin
            state <= ST_RESP;
            if (grant == GRANT_MEM) begin
              Mem_Data_o  <= finish_word;
              Mem_Valid_o <= 1'b1;
            end else begin
              IF_Data_o  <= finish_word;
              IF_Valid_o <= 1'b1;
            end
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_RESP: begin
          last_grant <= grant;
          Read_o     <= 1'b0;
          Write_o    <= 1'b0;
          Busy_o     <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef W0RM_BUS_TIMEOUT_EN
  // WAIT-cycle counter and error strobes that accompany a timed-out response.
  always_ff @(posedge BaseCLK) begin
    if (Reset) begin
      wait_cnt  <= '0;
      IF_Err_o  <= 1'b0;
      Mem_Err_o <= 1'b0;
    end else begin
      IF_Err_o  <= 1'b0;
      Mem_Err_o <= 1'b0;
      if (state == ST_IDLE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (finish && finish_err) begin
        if (grant == GRANT_MEM) Mem_Err_o <= 1'b1;
        else                    IF_Err_o  <= 1'b1;
      end
    end
  end
`else
  assign IF_Err_o  = 1'b0;
  assign Mem_Err_o = 1'b0;
  logic unused_err;
  assign unused_err = finish_err;
`endif

endmodule
`default_nettype wire
